f_coef_bank_sel: RTL and testbench
==================================

# f_coef_bank_sel

Parametrised, pipelined coefficient-bank selector for the bicubic datapath. Each beat carries BANKS candidate coefficient sets of LANES signed fixed-point words. The block forwards one set, chosen either by an explicit select or by an internal round-robin pointer, through a registered valid/ready stage with a skid buffer. It sits between the coefficient LUT/generator and the 4-tap multiply-accumulate stage, and replaces the fixed 4-lane, 2-way combinational selection with full-throughput backpressure support.

## Interface
- WIDTH, 15, bits per coefficient word
- LANES, 4, coefficient words per set (taps)
- BANKS, 2, candidate sets per beat; legal range 2..8
- SEL_W, $clog2(BANKS), select width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_data  in  BANKS*LANES*WIDTH  bank b lane l at bits [(b*LANES+l)*WIDTH +: WIDTH]
- in_sel  in  SEL_W  explicit bank select, used when mode=0
- mode  in  1  0 = explicit select, 1 = auto round-robin
- rr_clear  in  1  synchronous clear of round-robin pointer
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- out_data  out  LANES*WIDTH  selected set, lane l at [l*WIDTH +: WIDTH]
- out_bank  out  SEL_W  bank index used for out_data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output

## Operation
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Effective bank for an accepted beat:
  - mode=0: in_sel.
  - mode=1: rr_ptr.
  - rr_clear=1 in the accept cycle: bank 0, regardless of mode.
- Out-of-range bank (index >= BANKS, non-power-of-2 BANKS only): out_data is all zeros and out_bank carries the raw index.
- Round-robin pointer rr_ptr:
  - Advances by 1 on each accept while mode=1 and wraps from BANKS-1 to 0.
  - Holds when mode=0 or when no accept occurs.
  - rr_clear without an accept sets rr_ptr=0.
  - rr_clear with an accept (mode=1) sets rr_ptr=1 mod BANKS.
  - rr_clear with an accept (mode=0) sets rr_ptr=0.
- Selection is resolved at accept time. The mux output, not the raw input, is captured into storage.
- Storage is a main output register plus one skid register:
  - in_ready is registered and equals !skid_full.
  - Accept while main is full and not draining writes the beat to skid.
  - On output transfer, skid (if full) moves to main, otherwise main takes any new accept.
  - Ordering is strictly FIFO. No beat is ever dropped or duplicated.
- mode and in_sel are sampled only on accept. Changing them between beats is legal.

## Timing
- Reset values: out_valid=0, out_data=0, out_bank=0, in_ready=1, rr_ptr=0, skid empty.
- Latency: a beat accepted in cycle N is presented with out_valid=1 in cycle N+1 if main was empty or draining in cycle N.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Backpressure:
  - out_ready=0 with main full: one more beat is accepted into skid.
  - in_ready drops in the following cycle.
  - in_ready returns to 1 the cycle after the first output transfer frees skid.
- out_data and out_bank hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept and transfer with skid empty: main is reloaded in the same edge, and out_valid stays 1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Buffered beats are discarded.

## Structure
- Shared package f_interp_pkg holds:
  - COEF_W=15 and TAPS=4 constants.
  - The lane/bank slice offset function.
- One sub-module f_skid_reg (parameter DW) implements the main+skid valid/ready register. It is instantiated with DW=LANES*WIDTH+SEL_W.
- Selection mux and rr_ptr logic live in the top module.

## Test plan
- Reset release, BANKS=2, mode=0, in_sel=1, bank0 lanes={1,2,3,4}, bank1 lanes={0x7FFF,0x4000,0x0001,0x0000}, out_ready=1 -> out_valid one cycle after accept, out_data=bank1 lanes, out_bank=1.
- mode=1, BANKS=3, 7 consecutive beats with out_ready=1 -> out_bank sequence 0,1,2,0,1,2,0, one output per cycle, no bubbles.
- out_ready=0 for 4 cycles while in_valid=1 on every cycle -> exactly 2 beats accepted, in_ready=0 from the third cycle, output held stable. After out_ready=1, beats exit in order and in_ready returns.
- mode=1, pointer at 2 (BANKS=3), rr_clear asserted together with an accept -> that beat uses bank 0, and the next beat uses bank 1.
- BANKS=3, mode=0, in_sel=3 -> out_data=0, out_bank=3.
- rst_n pulsed low while skid is full -> out_valid=0 and in_ready=1 immediately. After reset release, no stale beat appears.

Source files
------------

// File: rtl/f_interp_pkg.sv
// f_interp_pkg: shared coefficient constants and lane/bank slice helper for the interpolation datapath
package f_interp_pkg;
  localparam int COEF_W = 15;
  localparam int TAPS = 4;
  function automatic int slice_off(input int b, input int l, input int lanes, input int width);
    return (b * lanes + l) * width;
  endfunction
endpackage

// File: rtl/f_skid_reg.sv
// f_skid_reg: registered valid/ready stage with one skid entry, full throughput, strict FIFO order
module f_skid_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  logic [DW-1:0] r_main, r_skid;
  logic          r_main_v, r_ready;
  logic          w_acc, w_xfer;
  assign w_acc     = in_valid && r_ready;
  assign w_xfer    = r_main_v && out_ready;
  assign in_ready  = r_ready;
  assign out_data  = r_main;
  assign out_valid = r_main_v;
  // skid drains into main before any new beat; main parks incoming beats in skid when stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_xfer && !r_ready) begin
      r_main  <= r_skid;
      r_ready <= 1'b1;
    end else if (w_xfer || !r_main_v) begin
      r_main_v <= w_acc;
      if (w_acc) r_main <= in_data;
    end else if (w_acc) begin
      r_skid  <= in_data;
      r_ready <= 1'b0;
    end
  end
endmodule

// File: rtl/f_coef_bank_sel.sv
// f_coef_bank_sel: picks one coefficient set per beat (explicit or round-robin) into a skid-buffered output
module f_coef_bank_sel
  import f_interp_pkg::*;
#(
  parameter  int WIDTH = COEF_W,
  parameter  int LANES = TAPS,
  parameter  int BANKS = 2,
  localparam int SEL_W = $clog2(BANKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BANKS*LANES*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        mode,
  input  logic                        rr_clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]            out_bank,
  output logic                        out_valid,
  input  logic                        out_ready
);
  localparam int DW = LANES * WIDTH;
  logic [SEL_W-1:0]    r_rr, w_bank, w_bank_inc, w_rr_base;
  logic [DW-1:0]       w_sel_data;
  logic [DW+SEL_W-1:0] w_out;
  logic                w_acc;
  assign w_acc      = in_valid && in_ready;
  assign w_bank     = rr_clear ? '0 : mode ? r_rr : in_sel;
  assign w_bank_inc = (w_bank == SEL_W'(BANKS - 1)) ? '0 : w_bank + 1'b1;
  assign w_rr_base  = rr_clear ? '0 : r_rr;
  // bank mux; an index with no matching bank leaves the set at zero
  always_comb begin
    w_sel_data = '0;
    for (int b = 0; b < BANKS; b++)
      for (int l = 0; l < LANES; l++)
        if (w_bank == SEL_W'(b)) w_sel_data[l*WIDTH +: WIDTH] = in_data[slice_off(b, l, LANES, WIDTH) +: WIDTH];
  end
  // round-robin pointer steps past the bank actually used, so a clear-with-accept lands on 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rr <= '0;
    else        r_rr <= (w_acc && mode) ? w_bank_inc : w_rr_base;
  end
  f_skid_reg #(.DW(DW + SEL_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({w_bank, w_sel_data}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (w_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );
  assign out_data = w_out[DW-1:0];
  assign out_bank = w_out[DW +: SEL_W];
endmodule

// File: tb/tb_f_coef_bank_sel.sv
// tb_f_coef_bank_sel: randomized and directed checks of the bank selector against a queue model
module tb_f_coef_bank_sel;
  localparam int W = 15, L = 4, B = 3, SW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [B*L*W-1:0] in_data = '0;
  logic [SW-1:0] in_sel = '0, out_bank;
  logic mode = 1'b0, rr_clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [L*W-1:0] out_data;
  logic [2*L*W-1:0] b_in_data = '0;
  logic b_sel = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_bank;
  logic [L*W-1:0] b_out_data;
  logic [L*W+SW-1:0] q[$];
  logic [L*W+SW-1:0] e;
  int rr = 0, passed = 0, total = 0;

  f_coef_bank_sel #(.WIDTH(W), .LANES(L), .BANKS(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .mode(mode), .rr_clear(rr_clear),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_bank(out_bank),
    .out_valid(out_valid), .out_ready(out_ready));
  f_coef_bank_sel #(.WIDTH(W), .LANES(L), .BANKS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_sel), .mode(1'b0), .rr_clear(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_bank(b_out_bank),
    .out_valid(b_out_valid), .out_ready(1'b1));

  function automatic logic [L*W+SW-1:0] ref_pick(input int bank);
    logic [L*W-1:0] d = '0;
    if (bank < B) for (int l = 0; l < L; l++) d[l*W +: W] = in_data[(bank*L+l)*W +: W];
    return {SW'(bank), d};
  endfunction

  task automatic step(input logic v, input logic [SW-1:0] sel, input logic md, input logic clr, input logic ordy);
    bit acc;
    int bank;
    logic [L*W+SW-1:0] item;
    in_valid = v; in_sel = sel; mode = md; rr_clear = clr; out_ready = ordy;
    for (int i = 0; i < B*L; i++) in_data[i*W +: W] = W'($urandom);
    acc = v && q.size() < 2;
    bank = clr ? 0 : md ? rr : int'(sel);
    item = ref_pick(bank);
    @(posedge clk); #1;
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(item);
    rr = (acc && md) ? (bank + 1) % B : (clr ? 0 : rr);
    e = q.size() > 0 ? q[0] : '0;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (out_valid === 1'b0 && in_ready === 1'b1 && out_data === '0 && out_bank === '0 && b_in_ready === 1'b1) passed++;
    else $display("FAIL reset: v=%b r=%b d=%h b=%h want v=0 r=1 d=0 b=0", out_valid, in_ready, out_data, out_bank);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_b2;
    @(negedge clk);
    b_in_data = {15'h0000, 15'h0001, 15'h4000, 15'h7FFF, 15'd4, 15'd3, 15'd2, 15'd1};
    b_sel = 1'b1; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    total++;
    if (b_out_valid === 1'b1 && b_out_bank === 1'b1 && b_out_data === {15'h0000, 15'h0001, 15'h4000, 15'h7FFF}) passed++;
    else $display("FAIL basic_b2: v=%b b=%b d=%h want v=1 b=1 d=%h", b_out_valid, b_out_bank, b_out_data, {15'h0000, 15'h0001, 15'h4000, 15'h7FFF});
    @(posedge clk); #1;
    total++;
    if (b_out_valid === 1'b0) passed++;
    else $display("FAIL basic_b2_drain: v=%b want 0", b_out_valid);
  endtask

  task automatic test_round_robin;
    int seq[7] = '{0, 1, 2, 0, 1, 2, 0};
    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 7; k++) begin
      step(1, SW'($urandom_range(0, 3)), 1, 0, 1);
      total++;
      if (out_valid === 1'b1 && in_ready === 1'b1 && out_bank === SW'(seq[k]) && {out_bank, out_data} === e) passed++;
      else $display("FAIL rr_seq[%0d]: v=%b r=%b o=%h want v=1 r=1 bank=%0d o=%h", k, out_valid, in_ready, {out_bank, out_data}, seq[k], e);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure;
    logic rdy_exp[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [L*W+SW-1:0] first;
    for (int k = 0; k < 4; k++) begin
      step(1, SW'($urandom_range(0, 2)), 0, 0, 0);
      if (k == 0) first = {out_bank, out_data};
      total++;
      if (out_valid === 1'b1 && in_ready === rdy_exp[k] && {out_bank, out_data} === e && {out_bank, out_data} === first) passed++;
      else $display("FAIL backpressure[%0d]: v=%b r=%b o=%h want v=1 r=%b o=%h", k, out_valid, in_ready, {out_bank, out_data}, rdy_exp[k], e);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if (out_valid === (q.size() != 0) && in_ready === 1'b1 && (!out_valid || {out_bank, out_data} === e)) passed++;
      else $display("FAIL bp_drain[%0d]: v=%b r=%b o=%h want v=%b r=1 o=%h", k, out_valid, in_ready, {out_bank, out_data}, q.size() != 0, e);
    end
  endtask

  task automatic test_rr_clear;
    step(0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 1);
    total++;
    if (out_valid === 1'b1 && out_bank === 2'd0 && {out_bank, out_data} === e) passed++;
    else $display("FAIL rr_clear_accept: v=%b o=%h want bank=0 o=%h", out_valid, {out_bank, out_data}, e);
    step(1, 0, 1, 0, 1);
    total++;
    if (out_valid === 1'b1 && out_bank === 2'd1 && {out_bank, out_data} === e) passed++;
    else $display("FAIL rr_after_clear: v=%b o=%h want bank=1 o=%h", out_valid, {out_bank, out_data}, e);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_oob;
    step(1, 2'd3, 0, 0, 1);
    total++;
    if (out_valid === 1'b1 && out_bank === 2'd3 && out_data === '0) passed++;
    else $display("FAIL oob: v=%b b=%0d d=%h want v=1 b=3 d=0", out_valid, out_bank, out_data);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom), SW'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      total++;
      if (out_valid === (q.size() != 0) && in_ready === (q.size() < 2) && (!out_valid || {out_bank, out_data} === e)) passed++;
      else $display("FAIL random[%0d]: v=%b r=%b o=%h want v=%b r=%b o=%h", k, out_valid, in_ready, {out_bank, out_data}, q.size() != 0, q.size() < 2, e);
    end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    total++;
    if (in_ready === 1'b0 && out_valid === 1'b1) passed++;
    else $display("FAIL skid_full: v=%b r=%b want v=1 r=0", out_valid, in_ready);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid === 1'b0 && in_ready === 1'b1 && out_data === '0) passed++;
    else $display("FAIL reset_mid: v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    q.delete();
    rr = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if (out_valid === 1'b0 && in_ready === 1'b1) passed++;
      else $display("FAIL reset_stale[%0d]: v=%b r=%b want v=0 r=1", k, out_valid, in_ready);
    end
    step(1, 0, 1, 0, 1);
    total++;
    if (out_valid === 1'b1 && out_bank === 2'd0 && {out_bank, out_data} === e) passed++;
    else $display("FAIL reset_rr: v=%b o=%h want bank=0 o=%h", out_valid, {out_bank, out_data}, e);
  endtask

  initial begin
    test_reset;
    test_basic_b2;
    test_round_robin;
    test_backpressure;
    test_rr_clear;
    test_oob;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
